iob_axis_fifo: RTL



---
 rtl/iob_axis_fifo.sv | 123 ++++++++++++
 1 files changed

// File: rtl/iob_axis_fifo.sv
// iob_axis_fifo: register-based AXI-Stream FIFO, first-word-fall-through, 2**ADDR_W words deep.
// Define IOB_AXIS_FIFO_TLAST_EN to store tlast with each word and count stored packet ends.
module iob_axis_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] s_tdata_i,
    input  logic              s_tvalid_i,
    output logic              s_tready_o,
`ifdef IOB_AXIS_FIFO_TLAST_EN
    input  logic              s_tlast_i,
    output logic              m_tlast_o,
    output logic [ADDR_W:0]   pkt_cnt_o,
`endif
    output logic [DATA_W-1:0] m_tdata_o,
    output logic              m_tvalid_o,
    input  logic              m_tready_i,
    output logic [ADDR_W:0]   level_o,
    output logic              empty_o,
    output logic              full_o
);
    localparam int unsigned Depth = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LevelFull = (ADDR_W + 1)'(Depth);
`ifdef IOB_AXIS_FIFO_TLAST_EN
    localparam int unsigned EntryW = DATA_W + 1;
`else
    localparam int unsigned EntryW = DATA_W;
`endif

    logic [EntryW-1:0] mem [Depth];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   level;
    logic [EntryW-1:0] wr_entry;
    logic [EntryW-1:0] rd_entry;
    logic              active;
    logic              push;
    logic              pop;

    // Handshakes depend only on registered level, never on m_tready_i, so s_tready_o has no
    // combinational path from the consumer. Reset also forces both sides idle.
    assign active     = arst_n_i & cke_i & ~rst_i;
    assign s_tready_o = active & (level != LevelFull);
    assign m_tvalid_o = active & (level != '0);
    assign push       = s_tvalid_i & s_tready_o;
    assign pop        = m_tvalid_o & m_tready_i;

    assign level_o = level;
    assign empty_o = (level == '0);
    assign full_o  = (level == LevelFull);

    assign rd_entry = mem[rd_ptr];
`ifdef IOB_AXIS_FIFO_TLAST_EN
    assign wr_entry  = {s_tlast_i, s_tdata_i};
    assign m_tdata_o = rd_entry[DATA_W-1:0];
    assign m_tlast_o = rd_entry[DATA_W];
`else
    assign wr_entry  = s_tdata_i;
    assign m_tdata_o = rd_entry;
`endif

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (cke_i) begin
            if (rst_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                end
                if (push && !pop) begin
                    level <= level + (ADDR_W + 1)'(1);
                end else if (pop && !push) begin
                    level <= level - (ADDR_W + 1)'(1);
                end
            end
        end
    end

`ifdef IOB_AXIS_FIFO_TLAST_EN
    logic             pkt_inc;
    logic             pkt_dec;
    logic [ADDR_W:0]  pkt_cnt;

    assign pkt_inc   = push & s_tlast_i;
    assign pkt_dec   = pop & rd_entry[DATA_W];
    assign pkt_cnt_o = pkt_cnt;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            pkt_cnt <= '0;
        end else if (cke_i) begin
            if (rst_i) begin
                pkt_cnt <= '0;
            end else if (pkt_inc && !pkt_dec) begin
                pkt_cnt <= pkt_cnt + (ADDR_W + 1)'(1);
            end else if (pkt_dec && !pkt_inc) begin
                pkt_cnt <= pkt_cnt - (ADDR_W + 1)'(1);
            end
        end
    end
`endif

endmodule
